// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks two N-bit operands MSB-first, CHUNK bits per clock,
// stopping at the first differing chunk and reporting EQ/LT/GT plus the number of chunks examined.
module serial_magnitude_comparator #(
  parameter int N     = 8,
  parameter int CHUNK = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         signed_mode,
  input  logic [N-1:0]                 A,
  input  logic [N-1:0]                 B,
  output logic                         busy,
  output logic                         done,
  output logic                         EQ,
  output logic                         LT,
  output logic                         GT,
  output logic [$clog2(N/CHUNK):0]     steps
);

  localparam int NCH = N / CHUNK;
  localparam int SW  = $clog2(NCH) + 1;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {IDLE, COMPARE} state_t;

  state_t            state, state_n;
  logic [IW-1:0]     idx, idx_n;
  logic [N-1:0]      a_reg, b_reg, a_n, b_n;
  logic [N-1:0]      a_sh, b_sh;
  logic [CHUNK-1:0]  chunk_a, chunk_b;
  logic              busy_n, done_n, eq_n, lt_n, gt_n;
  logic [SW-1:0]     steps_n;

  // Shifting the current chunk up to the MSB end keeps the select constant-width.
  always_comb begin
    a_sh    = a_reg << (CHUNK * int'(idx));
    b_sh    = b_reg << (CHUNK * int'(idx));
    chunk_a = a_sh[N-1 -: CHUNK];
    chunk_b = b_sh[N-1 -: CHUNK];
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    a_n     = a_reg;
    b_n     = b_reg;
    busy_n  = busy;
    done_n  = 1'b0;
    eq_n    = EQ;
    lt_n    = LT;
    gt_n    = GT;
    steps_n = steps;
    case (state)
      IDLE: begin
        if (start) begin
          // Inverting the sign bit maps two's-complement order onto unsigned order.
          a_n     = signed_mode ? {~A[N-1], A[N-2:0]} : A;
          b_n     = signed_mode ? {~B[N-1], B[N-2:0]} : B;
          idx_n   = '0;
          busy_n  = 1'b1;
          state_n = COMPARE;
        end
      end
      COMPARE: begin
        if (chunk_a != chunk_b) begin
          lt_n    = (chunk_a < chunk_b);
          gt_n    = !(chunk_a < chunk_b);
          eq_n    = 1'b0;
          steps_n = SW'(idx) + SW'(1);
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (idx == IW'(NCH - 1)) begin
          eq_n    = 1'b1;
          lt_n    = 1'b0;
          gt_n    = 1'b0;
          steps_n = SW'(NCH);
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          idx_n = idx + IW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      EQ    <= 1'b0;
      LT    <= 1'b0;
      GT    <= 1'b0;
      steps <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      a_reg <= a_n;
      b_reg <= b_n;
      busy  <= busy_n;
      done  <= done_n;
      EQ    <= eq_n;
      LT    <= lt_n;
      GT    <= gt_n;
      steps <= steps_n;
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator: an N=8/CHUNK=2 instance driven through a
// scoreboard, plus an N=16/CHUNK=4 instance for the wider configuration.
module tb_serial_magnitude_comparator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start1, sm1;
  logic [7:0] a1, b1;
  logic       busy1, done1, eq1, lt1, gt1;
  logic [2:0] steps1;

  logic        start2, sm2;
  logic [15:0] a2, b2;
  logic        busy2, done2, eq2, lt2, gt2;
  logic [2:0]  steps2;

  serial_magnitude_comparator #(.N(8), .CHUNK(2)) u_dut8 (
    .clk(clk), .rst(rst), .start(start1), .signed_mode(sm1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .EQ(eq1), .LT(lt1), .GT(gt1), .steps(steps1)
  );

  serial_magnitude_comparator #(.N(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start2), .signed_mode(sm2), .A(a2), .B(b2),
    .busy(busy2), .done(done2), .EQ(eq2), .LT(lt2), .GT(gt2), .steps(steps2)
  );

  typedef struct {
    logic eq;
    logic lt;
    logic gt;
    int   steps;
    int   acc;
    int   lat;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e, last_exp;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   dones = 0;
  int   last_done = 0;
  int   prev_done = 0;
  logic done_prev = 1'b0;
  logic [7:0] wa;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: integer compare for the flags, highest differing bit for the chunk count.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input bit sm,
                                 input int n, input int c);
    exp_t r;
    int va, vb, m;
    logic [15:0] x;
    va = int'(a);
    vb = int'(b);
    if (sm) begin
      if (a[n-1]) va = va - (1 << n);
      if (b[n-1]) vb = vb - (1 << n);
    end
    r.eq = (va == vb);
    r.lt = (va < vb);
    r.gt = (va > vb);
    x = a ^ b;
    m = -1;
    for (int i = 0; i < n; i++) if (x[i]) m = i;
    r.steps = (m < 0) ? n / c : (n - 1 - m) / c + 1;
    r.acc = 0;
    r.lat = r.steps;
    return r;
  endfunction

  // Scoreboard consumer for the 8-bit instance.
  always @(negedge clk) begin
    if (done1) begin
      checkOutput("done_single_cycle", 32'(done_prev), 32'd0);
      checkOutput("busy_at_done", 32'(busy1), 32'd0);
      if (sbq.size() == 0) begin
        checkOutput("unexpected_done", 32'(done1), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        checkOutput("EQ", 32'(eq1), 32'(mon_e.eq));
        checkOutput("LT", 32'(lt1), 32'(mon_e.lt));
        checkOutput("GT", 32'(gt1), 32'(mon_e.gt));
        checkOutput("steps", 32'(steps1), 32'(mon_e.steps));
        if (mon_e.lat > 0) checkOutput("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
      end
      prev_done = last_done;
      last_done = cyc;
      dones++;
    end
    done_prev = done1;
  end

  task automatic waitDone1(input int d0);
    int k;
    for (k = 0; k < 40; k++) begin
      if (dones > d0) break;
      @(negedge clk);
      #1;
    end
    if (dones <= d0) checkOutput("done_timeout", 32'(done1), 32'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input bit sm);
    exp_t e;
    int d0;
    d0 = dones;
    e = model({8'h00, a}, {8'h00, b}, sm, 8, 2);
    @(negedge clk);
    a1 = a; b1 = b; sm1 = sm; start1 = 1'b1;
    e.acc = cyc + 1;
    sbq.push_back(e);
    last_exp = e;
    @(negedge clk);
    start1 = 1'b0;
    checkOutput("busy_after_start", 32'(busy1), 32'd1);
    waitDone1(d0);
  endtask

  task automatic applyStimulus16(input logic [15:0] a, input logic [15:0] b, input bit sm);
    exp_t e;
    int acc, k;
    e = model(a, b, sm, 16, 4);
    @(negedge clk);
    a2 = a; b2 = b; sm2 = sm; start2 = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    start2 = 1'b0;
    for (k = 0; k < 40; k++) begin
      if (done2) break;
      @(negedge clk);
    end
    if (!done2) begin
      checkOutput("done16_timeout", 32'(done2), 32'd1);
    end else begin
      checkOutput("EQ16", 32'(eq2), 32'(e.eq));
      checkOutput("LT16", 32'(lt2), 32'(e.lt));
      checkOutput("GT16", 32'(gt2), 32'(e.gt));
      checkOutput("steps16", 32'(steps2), 32'(e.steps));
      checkOutput("latency16", 32'(cyc - acc), 32'(e.lat));
    end
  endtask

  initial begin
    int d0, k;
    rst = 1'b1;
    start1 = 1'b0; sm1 = 1'b0; a1 = '0; b1 = '0;
    start2 = 1'b0; sm2 = 1'b0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy1), 32'd0);
    checkOutput("reset_done", 32'(done1), 32'd0);
    checkOutput("reset_EQ", 32'(eq1), 32'd0);
    checkOutput("reset_LT", 32'(lt1), 32'd0);
    checkOutput("reset_GT", 32'(gt1), 32'd0);
    checkOutput("reset_steps", 32'(steps1), 32'd0);
    checkOutput("reset_busy16", 32'(busy2), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(8'hFF, 8'hFF, 1'b0);
    applyStimulus(8'h7F, 8'hFF, 1'b0);
    applyStimulus(8'hFE, 8'hFF, 1'b0);
    applyStimulus(8'h7F, 8'hFF, 1'b1);
    applyStimulus(8'h80, 8'h00, 1'b1);

    for (int i = 7; i >= 0; i--) begin
      wa = 8'hFF ^ (8'h01 << i);
      applyStimulus(wa, 8'hFF, 1'b0);
    end
    for (int i = 7; i >= 0; i--) begin
      wa = 8'hFF ^ (8'h01 << i);
      applyStimulus(8'hFF, wa, 1'b0);
    end

    // Result must hold while operands and mode change without a start.
    @(negedge clk);
    a1 = 8'h00; b1 = 8'hFF; sm1 = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("hold_EQ", 32'(eq1), 32'(last_exp.eq));
    checkOutput("hold_LT", 32'(lt1), 32'(last_exp.lt));
    checkOutput("hold_GT", 32'(gt1), 32'(last_exp.gt));
    checkOutput("hold_steps", 32'(steps1), 32'(last_exp.steps));
    checkOutput("hold_busy", 32'(busy1), 32'd0);

    // A start pulse on the second busy cycle must be ignored.
    d0 = dones;
    last_exp = model(16'h00FF, 16'h00FF, 1'b0, 8, 2);
    @(negedge clk);
    a1 = 8'hFF; b1 = 8'hFF; sm1 = 1'b0; start1 = 1'b1;
    last_exp.acc = cyc + 1;
    sbq.push_back(last_exp);
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    a1 = 8'h00; b1 = 8'hFF; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    #1;
    waitDone1(d0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("ignored_start_no_compare", 32'(busy1), 32'd0);

    // start held high: back-to-back compares with one idle cycle between them.
    d0 = dones;
    last_exp = model(16'h00FF, 16'h00FF, 1'b0, 8, 2);
    @(negedge clk);
    a1 = 8'hFF; b1 = 8'hFF; sm1 = 1'b0; start1 = 1'b1;
    last_exp.acc = cyc + 1;
    sbq.push_back(last_exp);
    last_exp.lat = 0;
    sbq.push_back(last_exp);
    #1;
    waitDone1(d0);
    if (sbq.size() > 0) begin
      sbq[0].acc = cyc + 1;
      sbq[0].lat = 4;
    end
    @(negedge clk);
    start1 = 1'b0;
    #1;
    waitDone1(d0 + 1);
    checkOutput("backtoback_gap", 32'(last_done - prev_done), 32'd5);

    // Reset in the second compare cycle aborts both instances.
    d0 = dones;
    @(negedge clk);
    a1 = 8'hFF; b1 = 8'hFF; start1 = 1'b1;
    a2 = 16'hFFFF; b2 = 16'hFFFF; sm2 = 1'b0; start2 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy1), 32'd0);
    checkOutput("abort_done", 32'(done1), 32'd0);
    checkOutput("abort_EQ", 32'(eq1), 32'd0);
    checkOutput("abort_LT", 32'(lt1), 32'd0);
    checkOutput("abort_GT", 32'(gt1), 32'd0);
    checkOutput("abort_steps", 32'(steps1), 32'd0);
    checkOutput("abort_busy16", 32'(busy2), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("abort_no_done16", 32'(done2), 32'd0);
    end
    #1;
    checkOutput("abort_no_done", 32'(dones - d0), 32'd0);

    applyStimulus(8'h01, 8'h02, 1'b0);
    applyStimulus16(16'h8000, 16'h8001, 1'b0);
    applyStimulus16(16'h8000, 16'h0001, 1'b1);
    applyStimulus16(16'h1234, 16'h1234, 1'b0);
    applyStimulus16(16'h0F00, 16'h0E00, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    checkOutput("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
